// File: rtl/sprite_packer_if.sv
// Handshake and BRAM write bundle between a sprite pixel source and the sprite packer.
// The master drives the pixel stream and start request; the slave returns the write port and status.
interface sprite_packer_if #(
    parameter int ADDR_W = 10
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              pix_valid;
    logic [3:0]        pix_idx;
    logic              pix_last;
    logic              pix_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, pix_valid, pix_idx, pix_last,
        input  pix_ready, wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  start, base_addr, pix_valid, pix_idx, pix_last,
        output pix_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/sprite_packer.sv
// Packs a raster stream of 4-bit palette indices into 32-bit words (pixel n in word n/8,
// nibble n%8) and writes them to the sprite BRAM starting at a latched base address.
module sprite_packer #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    sprite_packer_if.slave  bus
);
    localparam int              NPIX     = SPRITE_W * SPRITE_H;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_FLUSH, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [CNT_W-1:0]  r_pix_cnt;
    logic [2:0]        r_nib_cnt;
    logic [31:0]       r_acc;
    logic [31:0]       r_wr_data;
    logic [31:0]       w_word;
    logic              r_wr_en;
    logic              r_err;
    logic              w_beat;
    logic              w_final;

    assign w_beat  = bus.pix_valid && (r_state == S_PACK);
    assign w_final = (r_pix_cnt == LAST_PIX);

    // Accumulator with the current beat merged in, so a completed word includes it.
    always_comb begin
        w_word = r_acc;
        w_word[{r_nib_cnt, 2'b00} +: 4] = bus.pix_idx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_PACK;
            S_PACK: begin
                if (w_beat) begin
                    if (w_final)           w_next = S_DONE;
                    else if (bus.pix_last) w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Any write, including the partial word of an early last, is registered on the beat
    // itself; FLUSH is therefore the cycle in which that partial write is presented.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base     <= '0;
            r_word_cnt <= '0;
            r_pix_cnt  <= '0;
            r_nib_cnt  <= '0;
            r_acc      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state == S_IDLE && bus.start) begin
                r_base     <= bus.base_addr;
                r_word_cnt <= '0;
                r_pix_cnt  <= '0;
                r_nib_cnt  <= '0;
                r_acc      <= '0;
                r_err      <= 1'b0;
            end else if (w_beat) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
                r_nib_cnt <= r_nib_cnt + 1'b1;
                if (r_nib_cnt == 3'd7 || w_final || bus.pix_last) begin
                    r_wr_en    <= 1'b1;
                    r_wr_data  <= w_word;
                    r_wr_addr  <= r_base + r_word_cnt;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_acc      <= '0;
                end else begin
                    r_acc <= w_word;
                end
                if (w_final ? !bus.pix_last : bus.pix_last) r_err <= 1'b1;
            end
        end
    end

    assign bus.pix_ready = (r_state == S_PACK);
    assign bus.busy      = (r_state == S_PACK) || (r_state == S_FLUSH);
    assign bus.done      = (r_state == S_DONE);
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.err       = r_err;
endmodule

// File: doc/sprite_packer.md
Name: sprite_packer

Overview:
- Writer side of the sprite data path. Accepts a stream of 4-bit palette indices in raster order, one per accepted beat.
- Packs each group of 8 indices into a 32-bit word and writes that word to the sprite BRAM write port.
- The packed format is exactly what the sprite colour mappers unpack: pixel linear index n = x + y*SPRITE_W sits in word n/8 at bits [4*(n%8)+3 : 4*(n%8)].
- Used to load or replace sprite images (apple, snake segments) at start-up or on level change.

Parameters:
- SPRITE_W, 16, sprite width in pixels; SPRITE_W*SPRITE_H must be a multiple of 8.
- SPRITE_H, 16, sprite height in pixels.
- ADDR_W, 10, BRAM word-address width.
- CNT_W, 8, pixel-counter width; must satisfy 2^CNT_W >= SPRITE_W*SPRITE_H.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle request to begin loading one sprite.
- base_addr, in, ADDR_W, first word address of the target sprite; latched on an accepted start.
- pix_valid, in, 1, pix_idx is valid this cycle.
- pix_idx, in, 4, palette index of the current pixel.
- pix_last, in, 1, marks the final pixel of the stream; qualified by pix_valid.
- pix_ready, out, 1, packer accepts a beat this cycle.
- wr_en, out, 1, BRAM write strobe; high for one cycle per word.
- wr_addr, out, ADDR_W, BRAM word address.
- wr_data, out, 32, packed word.
- busy, out, 1, high in PACK and FLUSH.
- done, out, 1, one-cycle pulse when the load ends.
- err, out, 1, pix_last mismatch flag; sticky until the next accepted start or Reset.

Behaviour:
- Reset state: IDLE; pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0; accumulator and counters cleared.
- Beat acceptance: a beat is accepted when pix_valid && pix_ready. pix_ready is combinational: 1 only in PACK.
- States: IDLE, PACK, FLUSH, DONE.
- IDLE:
  - On start: latch base_addr, clear pixel count, nibble count and accumulator, clear err, go to PACK.
  - Inputs other than start are ignored.
- PACK, on an accepted beat:
  - Write pix_idx into accumulator nibble nib_cnt (nib 0 = bits[3:0]), then increment the pixel count.
  - When nib_cnt==7, the next cycle shows wr_en=1, wr_data = completed word (including the current beat), wr_addr = base + word_cnt. Then word_cnt increments and the accumulator clears.
  - Latency: 1 cycle from the 8th accepted beat to wr_en. Throughput is one pixel per cycle with no stall on word boundaries.
  - Final pixel is beat SPRITE_W*SPRITE_H-1:
    - with pix_last=1: write the word, go to DONE.
    - with pix_last=0: write the word, set err, go to DONE.
  - Early last (pix_last=1 before the final pixel): go to FLUSH and set err.
- FLUSH:
  - Writes the partial word (nibbles not yet received = 0) for one cycle, then goes to DONE.
  - If the early last beat was the 8th nibble of its word, the normal write is issued and FLUSH writes nothing.
- DONE: done=1 for exactly one cycle, then IDLE.
- wr_addr arithmetic: base_addr + word_cnt, truncated modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- Word count: exactly SPRITE_W*SPRITE_H/8 writes per normal load (32 at defaults).
- start while busy or in DONE: ignored, with no effect on latched base or counters.
- Reset mid-operation: returns to the reset state the next cycle. The partial word is discarded, no write is issued, and done is not pulsed.
- wr_en is never high on two consecutive cycles except at back-to-back word completions. It is never asserted in IDLE.

Test Plan:
- Full load, base=0x040, pix_valid constant, pix_idx=n%16, pix_last on n=255 → 32 writes at 0x040..0x05F. Even words = 0x76543210, odd words = 0xFEDCBA98. done pulses once; err=0; busy high from the cycle after start to the DONE cycle.
- Same stream with pix_valid low on every 3rd cycle → identical write sequence and data. pix_ready never drops in PACK.
- Early last: 10 pixels, idx 0..9, pix_last on the 10th → write 0x76543210 @base, then 0x00000098 @base+1. err=1, done pulse, no further writes.
- Missing last: 256 pixels, pix_last never set → 32 writes, err=1, done pulse.
- Reset asserted after 13 accepted beats → wr_en stays 0 afterwards and all outputs return to reset values. A following start with base=0x3FC wraps writes to 0x3FC..0x01B.
- start pulsed while busy with a different base_addr → ignored; writes continue at the original base.
- Round-trip check: pixel (x,y) nibble at word (x+16y)/8, bits 4*((x+16y)%8) matches the indices driven.
